// File: rtl/clk_div_gen.sv
// Programmable 50%-duty clock divider: div_clk_o high/low for cur_half_o clk cycles each.
// Latency: first HIGH starts the cycle after en_i is seen in IDLE; new half-periods apply at the next period boundary.
// Backpressure: one-deep config slot; cfg_ready_o drops while a value is pending and rises again when it is applied.
module clk_div_gen #(
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   input  logic [CNT_W-1:0] cfg_half_i,
   output logic             cfg_ready_o,
   output logic             div_clk_o,
   output logic             rise_o,
   output logic             applied_o,
   output logic [CNT_W-1:0] cur_half_o,
   output logic [31:0]      cyc_cnt_o
);

   localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cur_half;
   logic             pend_vld;
   logic [CNT_W-1:0] pend_half;

   logic             phase_end;
   logic             start_high;
   logic             accept;
   logic [CNT_W-1:0] next_half;
   logic [CNT_W-1:0] cfg_clamped;

   // Phase bookkeeping: when a HIGH phase starts and which half-period it will use.
   // A value captured in the pending slot on the same edge is not yet visible here,
   // so it can never be applied in the cycle it is accepted.
   always_comb begin
      phase_end   = (cnt == '0);
      start_high  = en_i & ((state == IDLE) | ((state == LOW) & phase_end));
      next_half   = pend_vld ? pend_half : cur_half;
      accept      = cfg_valid_i & ~pend_vld;
      cfg_clamped = (cfg_half_i == '0) ? ONE : cfg_half_i;
   end

   // One-deep pending config slot; it is drained by the HIGH phase that consumes it
   // and refuses new values while full, so a pending value is never overwritten.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_vld  <= 1'b0;
         pend_half <= DEF_HALF;
      end else if (start_high & pend_vld) begin
         pend_vld  <= 1'b0;
      end else if (accept) begin
         pend_vld  <= 1'b1;
         pend_half <= cfg_clamped;
      end
   end

   // Divider FSM with registered outputs; en_i only matters in IDLE and at the last LOW cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_half  <= DEF_HALF;
         div_clk_o <= 1'b0;
         rise_o    <= 1'b0;
         applied_o <= 1'b0;
         cyc_cnt_o <= 32'd0;
      end else begin
         rise_o    <= 1'b0;
         applied_o <= 1'b0;
         if (start_high) begin
            state     <= HIGH;
            div_clk_o <= 1'b1;
            rise_o    <= 1'b1;
            applied_o <= pend_vld;
            cur_half  <= next_half;
            cnt       <= next_half - ONE;
            cyc_cnt_o <= cyc_cnt_o + 32'd1;
         end else begin
            case (state)
               IDLE: begin
                  div_clk_o <= 1'b0;
               end
               HIGH: begin
                  if (phase_end) begin
                     state     <= LOW;
                     div_clk_o <= 1'b0;
                     cnt       <= cur_half - ONE;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               LOW: begin
                  if (phase_end) begin
                     state     <= IDLE;
                     div_clk_o <= 1'b0;
                  end else begin
                     cnt <= cnt - ONE;
                  end
               end
               default: begin
                  state     <= IDLE;
                  div_clk_o <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cfg_ready_o = ~pend_vld;
   assign cur_half_o  = cur_half;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: phase lengths, config hand-off, clamping, enable and reset.
module tb_clk_div_gen;

   logic        clk;
   logic        rst_n;
   logic        en_i;
   logic        cfg_valid_i;
   logic [15:0] cfg_half_i;
   logic        cfg_ready_o;
   logic        div_clk_o;
   logic        rise_o;
   logic        applied_o;
   logic [15:0] cur_half_o;
   logic [31:0] cyc_cnt_o;

   int n_chk;
   int n_pass;
   int n;

   clk_div_gen #(.CNT_W(16), .DEFAULT_HALF(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_half_i  (cfg_half_i),
      .cfg_ready_o (cfg_ready_o),
      .div_clk_o   (div_clk_o),
      .rise_o      (rise_o),
      .applied_o   (applied_o),
      .cur_half_o  (cur_half_o),
      .cyc_cnt_o   (cyc_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // advance one clock; outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // count consecutive samples with div_clk_o at lvl, bounded
   task automatic count_phase(input logic lvl, output int cnt);
      cnt = 0;
      while (div_clk_o === lvl && cnt < 1000) begin
         cnt++;
         step();
      end
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      en_i = 1'b1;
      cfg_valid_i = 1'b0;
      cfg_half_i = 16'd0;
      step();
      step();

      // reset state
      check("rst_div", {31'd0, div_clk_o}, 32'd0);
      check("rst_rise", {31'd0, rise_o}, 32'd0);
      check("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
      check("rst_half", {16'd0, cur_half_o}, 32'd10);
      check("rst_cyc", cyc_cnt_o, 32'd0);

      // 1: default 10/10 divider
      rst_n = 1'b1;
      step();
      check("t1_first_rise", {31'd0, rise_o}, 32'd1);
      check("t1_first_applied", {31'd0, applied_o}, 32'd0);
      for (int p = 0; p < 4; p++) begin
         count_phase(1'b1, n);
         check("t1_high_len", n, 32'd10);
         count_phase(1'b0, n);
         check("t1_low_len", n, 32'd10);
         check("t1_rise", {31'd0, rise_o}, 32'd1);
      end
      check("t1_cyc5", cyc_cnt_o, 32'd5);

      // 2: half=20 offered mid-HIGH, current period completes at 10/10
      step();
      step();
      step();
      cfg_valid_i = 1'b1;
      cfg_half_i = 16'd20;
      step();
      cfg_valid_i = 1'b0;
      check("t2_ready_low", {31'd0, cfg_ready_o}, 32'd0);
      check("t2_half_unchanged", {16'd0, cur_half_o}, 32'd10);
      count_phase(1'b1, n);
      check("t2_rest_high", n, 32'd6);
      count_phase(1'b0, n);
      check("t2_low_old", n, 32'd10);
      check("t2_applied", {31'd0, applied_o}, 32'd1);
      check("t2_rise", {31'd0, rise_o}, 32'd1);
      check("t2_half", {16'd0, cur_half_o}, 32'd20);
      check("t2_ready_back", {31'd0, cfg_ready_o}, 32'd1);
      count_phase(1'b1, n);
      check("t2_high20", n, 32'd20);
      count_phase(1'b0, n);
      check("t2_low20", n, 32'd20);
      check("t2_applied_once", {31'd0, applied_o}, 32'd0);

      // 3: back-to-back 15 then 7; the 7 stalls until 15 is applied
      cfg_valid_i = 1'b1;
      cfg_half_i = 16'd15;
      step();
      cfg_half_i = 16'd7;
      step();
      check("t3_stall", {31'd0, cfg_ready_o}, 32'd0);
      count_phase(1'b1, n);
      check("t3_rest_high20", n, 32'd18);
      count_phase(1'b0, n);
      check("t3_low20", n, 32'd20);
      check("t3_applied15", {31'd0, applied_o}, 32'd1);
      check("t3_half15", {16'd0, cur_half_o}, 32'd15);
      check("t3_ready_free", {31'd0, cfg_ready_o}, 32'd1);
      step();
      cfg_valid_i = 1'b0;
      check("t3_ready_took7", {31'd0, cfg_ready_o}, 32'd0);
      count_phase(1'b1, n);
      check("t3_rest_high15", n, 32'd14);
      count_phase(1'b0, n);
      check("t3_low15", n, 32'd15);
      check("t3_applied7", {31'd0, applied_o}, 32'd1);
      check("t3_half7", {16'd0, cur_half_o}, 32'd7);

      // 4: half=0 clamps to 1 -> 2-cycle period
      cfg_valid_i = 1'b1;
      cfg_half_i = 16'd0;
      step();
      cfg_valid_i = 1'b0;
      count_phase(1'b1, n);
      check("t4_rest_high7", n, 32'd6);
      count_phase(1'b0, n);
      check("t4_low7", n, 32'd7);
      check("t4_applied", {31'd0, applied_o}, 32'd1);
      check("t4_half1", {16'd0, cur_half_o}, 32'd1);
      count_phase(1'b1, n);
      check("t4_high1", n, 32'd1);
      count_phase(1'b0, n);
      check("t4_low1", n, 32'd1);
      check("t4_rise", {31'd0, rise_o}, 32'd1);

      // 5: en_i glitch mid-LOW is ignored; en_i low at boundary parks in IDLE
      cfg_valid_i = 1'b1;
      cfg_half_i = 16'd4;
      step();
      cfg_valid_i = 1'b0;
      count_phase(1'b0, n);
      check("t5_low1", n, 32'd1);
      check("t5_half4", {16'd0, cur_half_o}, 32'd4);
      count_phase(1'b1, n);
      check("t5_high4", n, 32'd4);
      en_i = 1'b0;
      step();
      en_i = 1'b1;
      count_phase(1'b0, n);
      check("t5_glitch_low_rest", n, 32'd3);
      check("t5_glitch_rise", {31'd0, rise_o}, 32'd1);
      check("t5_cyc13", cyc_cnt_o, 32'd13);
      en_i = 1'b0;
      count_phase(1'b1, n);
      check("t5_high_before_idle", n, 32'd4);
      for (int k = 0; k < 8; k++) begin
         check("t5_idle_div", {31'd0, div_clk_o}, 32'd0);
         step();
      end
      check("t5_idle_rise", {31'd0, rise_o}, 32'd0);
      check("t5_idle_cyc", cyc_cnt_o, 32'd13);
      en_i = 1'b1;
      step();
      check("t5_reen_rise", {31'd0, rise_o}, 32'd1);
      check("t5_reen_div", {31'd0, div_clk_o}, 32'd1);
      check("t5_cyc14", cyc_cnt_o, 32'd14);

      // 6: reset mid-HIGH with a pending config
      cfg_valid_i = 1'b1;
      cfg_half_i = 16'd9;
      step();
      cfg_valid_i = 1'b0;
      check("t6_pending", {31'd0, cfg_ready_o}, 32'd0);
      rst_n = 1'b0;
      step();
      check("t6_div", {31'd0, div_clk_o}, 32'd0);
      check("t6_ready", {31'd0, cfg_ready_o}, 32'd1);
      check("t6_half", {16'd0, cur_half_o}, 32'd10);
      check("t6_cyc", cyc_cnt_o, 32'd0);
      check("t6_rise", {31'd0, rise_o}, 32'd0);
      rst_n = 1'b1;
      step();
      check("t6_rise_after", {31'd0, rise_o}, 32'd1);
      check("t6_no_applied", {31'd0, applied_o}, 32'd0);
      count_phase(1'b1, n);
      check("t6_high10", n, 32'd10);
      check("t6_cyc1", cyc_cnt_o, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
